voice_allocator: RTL

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/synth_pkg.sv | 15 +
 rtl/note_period_rom.sv | 41 ++++
 rtl/voice_allocator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, default voice count and allocator state type
package synth_pkg;

    localparam int PERIOD_W           = 23;
    localparam int VOL_W              = 7;
    localparam int NOTE_W             = 7;
    localparam int DEFAULT_NUM_VOICES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2
    } alloc_state_t;

endpackage

// File: rtl/note_period_rom.sv
// rtl/note_period_rom.sv - 128-entry MIDI note to sine period table (clk cycles at 50 MHz)
module note_period_rom
    import synth_pkg::*;
(
    input  logic [NOTE_W-1:0]   note,
    output logic [PERIOD_W-1:0] period
);

    localparam int FRAC_W = 8;

    logic [3:0]  octave;
    logic [3:0]  semitone;
    logic [31:0] base;
    logic [31:0] rounded;
    logic [4:0]  shift;

    // base holds the exact lowest-octave period with 8 fraction bits; each
    // octave up halves it, and the final shift rounds to nearest.
    always_comb begin
        octave   = 4'(note / 7'd12);
        semitone = 4'(note % 7'd12);
        case (semitone)
            4'd0:    base = 32'd1565596235;
            4'd1:    base = 32'd1477726070;
            4'd2:    base = 32'd1394787679;
            4'd3:    base = 32'd1316504262;
            4'd4:    base = 32'd1242614555;
            4'd5:    base = 32'd1172871959;
            4'd6:    base = 32'd1107043714;
            4'd7:    base = 32'd1044910125;
            4'd8:    base = 32'd986263826;
            4'd9:    base = 32'd930909091;
            4'd10:   base = 32'd878661178;
            default: base = 32'd829345716;
        endcase
        shift   = 5'(FRAC_W) + 5'(octave);
        rounded = base + (32'd1 << (shift - 5'd1));
        period  = PERIOD_W'(rounded >> shift);
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - MIDI note event to sine voice allocator with retrigger and oldest-voice stealing
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int AGE_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_on,
    input  logic [NOTE_W-1:0]              ev_note,
    input  logic [VOL_W-1:0]               ev_velocity,
    output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
    output logic [NUM_VOICES*VOL_W-1:0]    voice_volume,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES-1:0]          voice_restart,
    output logic [7:0]                     steal_count
);

    localparam int                IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0]  AGE_MAX  = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t          state;
    logic                  lat_on;
    logic [NOTE_W-1:0]     lat_note;
    logic [VOL_W-1:0]      lat_vel;
    logic [IDX_W-1:0]      scan_idx;

    logic                  hit_found;
    logic [IDX_W-1:0]      hit_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;
    logic [NUM_VOICES-1:0] off_mask;

    logic [NOTE_W-1:0]     voice_note [NUM_VOICES];
    logic [AGE_W-1:0]      voice_age  [NUM_VOICES];
    logic [PERIOD_W-1:0]   rom_period;

    logic                  cur_active;
    logic                  cur_match;
    logic [AGE_W-1:0]      cur_age;
    logic [IDX_W-1:0]      sel_idx;
    logic                  do_steal;

    note_period_rom u_note_period_rom (
        .note   (lat_note),
        .period (rom_period)
    );

    assign cur_active = voice_active[scan_idx];
    assign cur_age    = voice_age[scan_idx];
    assign cur_match  = cur_active && (voice_note[scan_idx] == lat_note);

    always_comb begin
        do_steal = 1'b0;
        if (hit_found) begin
            sel_idx = hit_idx;
        end else if (free_found) begin
            sel_idx = free_idx;
        end else begin
            sel_idx  = old_idx;
            do_steal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ev_ready      <= 1'b1;
            lat_on        <= 1'b0;
            lat_note      <= '0;
            lat_vel       <= '0;
            scan_idx      <= '0;
            hit_found     <= 1'b0;
            hit_idx       <= '0;
            free_found    <= 1'b0;
            free_idx      <= '0;
            old_idx       <= '0;
            old_age       <= '0;
            off_mask      <= '0;
            voice_period  <= '0;
            voice_volume  <= '0;
            voice_active  <= '0;
            voice_restart <= '0;
            steal_count   <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_note[i] <= '0;
                voice_age[i]  <= '0;
            end
        end else begin
            voice_restart <= '0;
            case (state)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        lat_on     <= ev_on && (ev_velocity != '0);
                        lat_note   <= ev_note;
                        lat_vel    <= ev_velocity;
                        scan_idx   <= '0;
                        hit_found  <= 1'b0;
                        free_found <= 1'b0;
                        old_idx    <= '0;
                        old_age    <= '0;
                        off_mask   <= '0;
                        ev_ready   <= 1'b0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        off_mask[scan_idx] <= 1'b1;
                        if (!hit_found) begin
                            hit_found <= 1'b1;
                            hit_idx   <= scan_idx;
                        end
                    end
                    if (!cur_active && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // strict compare keeps the lowest index on equal ages
                    if (cur_active && (cur_age > old_age)) begin
                        old_idx <= scan_idx;
                        old_age <= cur_age;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= APPLY;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                APPLY: begin
                    if (lat_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == sel_idx) begin
                                voice_active[i]                     <= 1'b1;
                                voice_period[i*PERIOD_W +: PERIOD_W] <= rom_period;
                                voice_volume[i*VOL_W +: VOL_W]       <= lat_vel;
                                voice_note[i]                       <= lat_note;
                                voice_age[i]                        <= '0;
                                voice_restart[i]                    <= 1'b1;
                            end else if (voice_active[i] && (voice_age[i] != AGE_MAX)) begin
                                voice_age[i] <= voice_age[i] + AGE_W'(1);
                            end
                        end
                        if (do_steal && (steal_count != 8'hFF)) begin
                            steal_count <= steal_count + 8'd1;
                        end
                    end else begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (off_mask[i]) begin
                                voice_active[i]               <= 1'b0;
                                voice_volume[i*VOL_W +: VOL_W] <= '0;
                            end
                        end
                    end
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    ev_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
